updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
Parametrised synchronous up/down counter, the fully synchronous successor to the 4-bit ripple up/down counter. All state bits share one clock; there are no derived clocks. Adds a programmable modulus, parallel load, synchronous clear, wrap or saturate mode, a cascade terminal-count output and sticky overflow/underflow flags. Used as a general event/position counter and cascadable for wider counts.

Parameters:
WIDTH, 4, counter width in bits (>=1).
MODULUS, 16, count range is 0..MODULUS-1. Must satisfy 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 = wrap at the range limits, 1 = hold at the range limits.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
en  in  1  count enable; one step per cycle while high.
dir  in  1  0 = count up, 1 = count down.
clear  in  1  synchronous clear of the count to 0.
load  in  1  synchronous parallel load.
load_val  in  WIDTH  value for load.
clr_flags  in  1  clears the sticky flags.
q  out  WIDTH  current count (registered).
tc  out  1  combinational terminal count: en & ((~dir & q==MODULUS-1) | (dir & q==0)).
wrap  out  1  registered one-cycle pulse, high the cycle after a limit crossing or a saturated limit hit.
ovf  out  1  sticky: an up-count attempt at MODULUS-1.
udf  out  1  sticky: a down-count attempt at 0.

Behaviour:
- Reset (rst=1 at a clk edge): q=0, wrap=0, ovf=0, udf=0. Reset overrides every other input. tc follows from q=0, so tc=en&dir.
- Count priority per edge: rst > clear > load > en. Lower-priority actions are ignored in that cycle.
- clear: q<=0, wrap<=0. Flags are unchanged.
- load: q<=load_val if load_val<MODULUS; otherwise q<=MODULUS-1 (clamp). wrap<=0. Flags are unchanged.
- en=1, dir=0, q<MODULUS-1: q<=q+1. Arithmetic is WIDTH bits wide and never exceeds MODULUS-1.
- en=1, dir=1, q>0: q<=q-1.
- en=1, dir=0, q==MODULUS-1: SATURATE=0 gives q<=0; SATURATE=1 leaves q unchanged. In both cases wrap<=1 and ovf<=1.
- en=1, dir=1, q==0: SATURATE=0 gives q<=MODULUS-1; SATURATE=1 leaves q unchanged. In both cases wrap<=1 and udf<=1.
- en=0 with no clear or load: q holds, wrap<=0.
- wrap is high for exactly one cycle per limit event. With consecutive limit events (for example SATURATE=1 held at the limit with en=1), it stays high on each of those cycles.
- Flags: clr_flags=1 clears ovf and udf. If a new set event occurs in the same cycle, set wins.
- A dir change takes effect on the next edge. There is no latency or pipeline: q updates on the edge where the condition is sampled.
- Cascading: connect stage N+1 en to stage N tc (same dir). The chain yields a combined modulus MODULUS^k.
- Non-power-of-two MODULUS: q never takes values >= MODULUS except via the clamp rule (which also prevents it).

Test Plan:
- Reset/up-wrap (WIDTH=4, MODULUS=10, SATURATE=0): rst 1 cycle, en=1, dir=0 for 12 cycles -> q 0,1,…,9,0,1. tc=1 only while q=9. wrap pulses the cycle q shows 0. ovf=1 afterwards, udf=0.
- Down-wrap/flags: load 2, dir=1, en=1 for 4 cycles -> q 2,1,0,9,8. udf sets. Then pulse clr_flags with en=0 -> udf=0. clr_flags and underflow in the same cycle -> udf stays 1.
- Saturate (MODULUS=16, SATURATE=1): load 14, up for 4 cycles -> q 14,15,15,15. wrap is high on both hold cycles and ovf=1. Then down from 0 -> q stays 0 and udf=1.
- Priority: in one cycle rst=0, clear=1, load=1, load_val=5, en=1 -> q=0. Next cycle clear=0, load=1, en=1 -> q=5 with no increment. Load of 12 with MODULUS=10 -> q=9.
- Mid-operation reset: count up to 7, then assert rst with en=1, load=1 and clear held -> next edge q=0, wrap=0, ovf=0, udf=0. Release rst -> counting resumes from 0.
- Cascade: two instances (MODULUS=10) chained via tc, count up 105 cycles -> {hi,lo}={0,5} after wrap of 100. Hi-stage wrap pulses once.

Source files
------------

// File: rtl/updown_counter_param_if.sv
// Control and status bundle for updown_counter_param.
// No handshake: the counter samples every input on each rising clk edge.
interface updown_counter_param_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             dir;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_flags;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf;
    logic             udf;

    modport master (
        output en, dir, clear, load, load_val, clr_flags,
        input  q, tc, wrap, ovf, udf
    );

    modport slave (
        input  en, dir, clear, load, load_val, clr_flags,
        output q, tc, wrap, ovf, udf
    );
endinterface

// File: rtl/updown_counter_param.sv
// Synchronous up/down counter with programmable modulus, load/clear,
// wrap or saturate at the limits, cascade terminal count and sticky flags.
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    updown_counter_param_if.slave bus
);
    // Top of the count range; MODULUS may equal 2**WIDTH, so MAX can be all ones.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_r;
    logic             wrap_nxt;
    logic             ovf_r;
    logic             udf_r;
    logic             ovf_set;
    logic             udf_set;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q_r == MAX);
    assign at_zero = (q_r == '0);

    always_comb begin
        q_nxt    = q_r;
        wrap_nxt = 1'b0;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        if (bus.clear) begin
            q_nxt = '0;
        end else if (bus.load) begin
            // Out-of-range loads clamp so q never leaves 0..MODULUS-1.
            q_nxt = (bus.load_val > MAX) ? MAX : bus.load_val;
        end else if (bus.en) begin
            if (!bus.dir) begin
                if (at_max) begin
                    wrap_nxt = 1'b1;
                    ovf_set  = 1'b1;
                    q_nxt    = SATURATE ? q_r : '0;
                end else begin
                    q_nxt = q_r + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    wrap_nxt = 1'b1;
                    udf_set  = 1'b1;
                    q_nxt    = SATURATE ? q_r : MAX;
                end else begin
                    q_nxt = q_r - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            ovf_r  <= 1'b0;
            udf_r  <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            wrap_r <= wrap_nxt;
            // A set event in the same cycle as clr_flags wins.
            ovf_r  <= ovf_set | (ovf_r & ~bus.clr_flags);
            udf_r  <= udf_set | (udf_r & ~bus.clr_flags);
        end
    end

    assign bus.q    = q_r;
    assign bus.tc   = bus.en & ((~bus.dir & at_max) | (bus.dir & at_zero));
    assign bus.wrap = wrap_r;
    assign bus.ovf  = ovf_r;
    assign bus.udf  = udf_r;
endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: wrap, saturate and cascaded instances
// checked every cycle against an arithmetic model plus literal expectations.
module tb_updown_counter_param;
  typedef struct {
    int q;
    bit wrap;
    bit ovf;
    bit udf;
  } m_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  updown_counter_param_if #(.WIDTH(4)) if_a ();
  updown_counter_param_if #(.WIDTH(4)) if_s ();
  updown_counter_param_if #(.WIDTH(4)) if_l ();
  updown_counter_param_if #(.WIDTH(4)) if_h ();

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  updown_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
  updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(if_l));
  updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_h (.clk(clk), .rst(rst), .bus(if_h));

  // Cascade: high stage steps on the low stage terminal count.
  assign if_h.en  = if_l.tc;
  assign if_h.dir = if_l.dir;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;
  bit casc_on  = 1'b0;
  int hi_wraps = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference next-state from the rules: modulo arithmetic, clamp, sticky flags.
  function automatic m_t step(input m_t s, input int modulus, input bit sat, input bit r,
                              input bit clr, input bit ld, input int lv, input bit en,
                              input bit dn, input bit cf);
    m_t n;
    n = s;
    n.wrap = 1'b0;
    if (r) begin
      n.q = 0; n.ovf = 0; n.udf = 0;
      return n;
    end
    if (cf) begin
      n.ovf = 0; n.udf = 0;
    end
    if (clr) n.q = 0;
    else if (ld) n.q = (lv >= modulus) ? modulus - 1 : lv;
    else if (en && !dn) begin
      if (s.q == modulus - 1) begin
        n.wrap = 1; n.ovf = 1;
        n.q = sat ? s.q : 0;
      end else n.q = (s.q + 1) % modulus;
    end else if (en && dn) begin
      if (s.q == 0) begin
        n.wrap = 1; n.udf = 1;
        n.q = sat ? 0 : modulus - 1;
      end else n.q = (s.q + modulus - 1) % modulus;
    end
    return n;
  endfunction

  function automatic bit tc_of(input m_t s, input int modulus, input bit en, input bit dn);
    return en && (dn ? (s.q == 0) : (s.q == modulus - 1));
  endfunction

  m_t ma = '{0, 0, 0, 0};
  m_t ms = '{0, 0, 0, 0};
  m_t ml = '{0, 0, 0, 0};
  m_t mh = '{0, 0, 0, 0};

  always @(posedge clk) begin
    bit tcl;
    tcl = tc_of(ml, 10, if_l.en, if_l.dir);
    ma = step(ma, 10, 0, rst, if_a.clear, if_a.load, int'(if_a.load_val), if_a.en, if_a.dir, if_a.clr_flags);
    ms = step(ms, 16, 1, rst, if_s.clear, if_s.load, int'(if_s.load_val), if_s.en, if_s.dir, if_s.clr_flags);
    mh = step(mh, 10, 0, rst, if_h.clear, if_h.load, int'(if_h.load_val), tcl, if_l.dir, if_h.clr_flags);
    ml = step(ml, 10, 0, rst, if_l.clear, if_l.load, int'(if_l.load_val), if_l.en, if_l.dir, if_l.clr_flags);
    if (rst) chk_on = 1'b1;
  end

  task automatic cmp_inst(input string tag, input m_t m, input bit tc_exp, input logic [3:0] q,
                          input logic tc, input logic wrap, input logic ovf, input logic udf);
    check({tag, ".q"},    int'(q),    m.q);
    check({tag, ".tc"},   int'(tc),   int'(tc_exp));
    check({tag, ".wrap"}, int'(wrap), int'(m.wrap));
    check({tag, ".ovf"},  int'(ovf),  int'(m.ovf));
    check({tag, ".udf"},  int'(udf),  int'(m.udf));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_inst("a", ma, tc_of(ma, 10, if_a.en, if_a.dir), if_a.q, if_a.tc, if_a.wrap, if_a.ovf, if_a.udf);
      cmp_inst("s", ms, tc_of(ms, 16, if_s.en, if_s.dir), if_s.q, if_s.tc, if_s.wrap, if_s.ovf, if_s.udf);
      cmp_inst("lo", ml, tc_of(ml, 10, if_l.en, if_l.dir), if_l.q, if_l.tc, if_l.wrap, if_l.ovf, if_l.udf);
      cmp_inst("hi", mh, tc_of(mh, 10, tc_of(ml, 10, if_l.en, if_l.dir), if_l.dir),
               if_h.q, if_h.tc, if_h.wrap, if_h.ovf, if_h.udf);
      if (casc_on && if_h.wrap) hi_wraps++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    {if_a.en, if_a.dir, if_a.clear, if_a.load, if_a.clr_flags} = '0;
    {if_s.en, if_s.dir, if_s.clear, if_s.load, if_s.clr_flags} = '0;
    {if_l.en, if_l.dir, if_l.clear, if_l.load, if_l.clr_flags} = '0;
    {if_h.clear, if_h.load, if_h.clr_flags} = '0;
    if_a.load_val = '0; if_s.load_val = '0; if_l.load_val = '0; if_h.load_val = '0;

    // Reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("reset_q", int'(if_a.q), 0);
    check("reset_flags", int'({if_a.wrap, if_a.ovf, if_a.udf}), 0);

    // Up count through the wrap at 9
    if_a.en = 1'b1; if_a.dir = 1'b0;
    tick(9);
    check("up_q9", int'(if_a.q), 9);
    check("up_tc_at9", int'(if_a.tc), 1);
    tick(1);
    check("up_wrap_q", int'(if_a.q), 0);
    check("up_wrap_pulse", int'(if_a.wrap), 1);
    tick(2);
    check("up_q2", int'(if_a.q), 2);
    check("up_ovf", int'(if_a.ovf), 1);
    check("up_udf", int'(if_a.udf), 0);

    // Down through zero, then flag clearing
    if_a.en = 1'b0; if_a.load = 1'b1; if_a.load_val = 4'd2;
    tick(1);
    if_a.load = 1'b0; if_a.en = 1'b1; if_a.dir = 1'b1;
    tick(4);
    check("down_q8", int'(if_a.q), 8);
    check("down_udf", int'(if_a.udf), 1);
    if_a.en = 1'b0; if_a.clr_flags = 1'b1;
    tick(1);
    check("clr_udf", int'(if_a.udf), 0);
    check("clr_ovf", int'(if_a.ovf), 0);
    if_a.clr_flags = 1'b0; if_a.load = 1'b1; if_a.load_val = 4'd0;
    tick(1);
    if_a.load = 1'b0; if_a.en = 1'b1; if_a.clr_flags = 1'b1;
    tick(1);
    check("setwins_udf", int'(if_a.udf), 1);
    check("setwins_q", int'(if_a.q), 9);

    // Priority: clear > load > en, then clamp
    if_a.clr_flags = 1'b0; if_a.dir = 1'b0;
    if_a.clear = 1'b1; if_a.load = 1'b1; if_a.load_val = 4'd5;
    tick(1);
    check("prio_clear", int'(if_a.q), 0);
    if_a.clear = 1'b0;
    tick(1);
    check("prio_load", int'(if_a.q), 5);
    if_a.load_val = 4'd12;
    tick(1);
    check("load_clamp", int'(if_a.q), 9);

    // Mid-operation reset with everything else asserted
    if_a.load_val = 4'd0;
    tick(1);
    if_a.load = 1'b0;
    tick(7);
    check("mid_q7", int'(if_a.q), 7);
    rst = 1'b1; if_a.clear = 1'b1; if_a.load = 1'b1;
    tick(1);
    check("mid_rst_q", int'(if_a.q), 0);
    check("mid_rst_flags", int'({if_a.wrap, if_a.ovf, if_a.udf}), 0);
    rst = 1'b0; if_a.clear = 1'b0; if_a.load = 1'b0;
    tick(1);
    check("resume_q", int'(if_a.q), 1);
    if_a.en = 1'b0;

    // Saturate at 15 and at 0
    if_s.load = 1'b1; if_s.load_val = 4'd14;
    tick(1);
    if_s.load = 1'b0; if_s.en = 1'b1; if_s.dir = 1'b0;
    tick(1);
    check("sat_q15", int'(if_s.q), 15);
    check("sat_nowrap", int'(if_s.wrap), 0);
    tick(1);
    check("sat_hold1", int'(if_s.q), 15);
    check("sat_wrap1", int'(if_s.wrap), 1);
    tick(1);
    check("sat_wrap2", int'(if_s.wrap), 1);
    check("sat_ovf", int'(if_s.ovf), 1);
    if_s.en = 1'b0; if_s.load = 1'b1; if_s.load_val = 4'd0;
    tick(1);
    if_s.load = 1'b0; if_s.en = 1'b1; if_s.dir = 1'b1;
    tick(1);
    check("sat_q0", int'(if_s.q), 0);
    check("sat_udf", int'(if_s.udf), 1);
    if_s.en = 1'b0;
    tick(1);

    // Cascade of two decades
    casc_on = 1'b1;
    if_l.en = 1'b1; if_l.dir = 1'b0;
    tick(105);
    if_l.en = 1'b0;
    tick(1);
    casc_on = 1'b0;
    check("casc_hi", int'(if_h.q), 0);
    check("casc_lo", int'(if_l.q), 5);
    check("casc_hi_wraps", hi_wraps, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
